// File: rtl/line_buffer_ctrl_pkg.sv
// Shared encodings for the 3x3 line-buffer controller: FSM state codes,
// top-padding codes and a small line-mask helper.
package line_buffer_ctrl_pkg;

    typedef logic [2:0] lbc_state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LINE = 3'd1;
    localparam logic [2:0] ST_READ      = 3'd2;
    localparam logic [2:0] ST_ROW_END   = 3'd3;
    localparam logic [2:0] ST_FRAME_END = 3'd4;

    // Top padding of the read window: TOP2 zeroes rows 1 and 2, TOP1 zeroes row 2.
    localparam logic [1:0] PAD_NONE = 2'd0;
    localparam logic [1:0] PAD_TOP2 = 2'd1;
    localparam logic [1:0] PAD_TOP1 = 2'd2;

    function automatic logic [3:0] line_mask(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Controller for four rotating line buffers: gates camera writes, sequences
// 3x3 window reads row by row and recycles lines once they leave the window.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_frame_start,
    input  logic       in_pixel_valid,
    input  logic [3:0] in_full,
    input  logic       in_ready,
    output logic       ou_data_valid,
    output logic [1:0] ou_line_en_selection,
    output logic [1:0] ou_buffer_select,
    output logic       ou_rden,
    output logic [3:0] ou_re_read,
    output logic [3:0] ou_rst_line,
    output logic [1:0] ou_load_new_frame,
    output logic       ou_window_valid,
    output logic       ou_frame_done,
    output logic       ou_overflow
);

    localparam int            XW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int            YW      = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_LINES = YW'(HEIGHT);

    // Reset asserts immediately but is released only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_ni;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_ni = rst_sync_q[1];

    lbc_state_t    state_q, state_d;
    logic [1:0]    wr_line_q, wr_line_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic [YW-1:0] k_q, k_d;
    logic          ovf_q, ovf_d;
    logic          rden_p1_q;

    logic          frame_abort;
    logic          row_active;
    logic          row0, row1;
    logic [1:0]    k_line;
    logic [1:0]    win_sel;
    logic [1:0]    pad;
    logic [3:0]    rst_line;
    logic [3:0]    re_read;
    logic          rden;
    logic          frame_done;
    logic          wr_room, wr_block, wr_take, wr_drop;

    assign frame_abort = in_frame_start && (state_q != ST_IDLE);
    assign row_active  = (state_q == ST_WAIT_LINE) || (state_q == ST_READ) ||
                         (state_q == ST_ROW_END);
    assign row0        = (k_q == '0);
    assign row1        = (k_q == YW'(1));
    assign k_line      = k_q[1:0];
    assign win_sel     = (row0 || row1) ? 2'd0 : (k_line - 2'd2);
    assign pad         = row0 ? PAD_TOP2 : (row1 ? PAD_TOP1 : PAD_NONE);

    // Read-side FSM: row k waits for line k, reads WIDTH windows, then recycles.
    always_comb begin
        state_d    = state_q;
        rd_x_d     = rd_x_q;
        k_d        = k_q;
        rden       = 1'b0;
        re_read    = 4'h0;
        rst_line   = 4'h0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_frame_start) begin
                    state_d = ST_WAIT_LINE;
                end
            end
            ST_WAIT_LINE: begin
                if (in_full[k_line]) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rden = in_ready;
                if (in_ready) begin
                    if (rd_x_q == X_LAST) begin
                        rd_x_d  = '0;
                        state_d = ST_ROW_END;
                    end else begin
                        rd_x_d = rd_x_q + XW'(1);
                    end
                end
            end
            ST_ROW_END: begin
                if (row0) begin
                    re_read = line_mask(2'd0);
                end else if (row1) begin
                    re_read = line_mask(2'd0) | line_mask(2'd1);
                end else begin
                    // The oldest line leaves the window; the other two are re-read next row.
                    rst_line = line_mask(win_sel);
                    re_read  = line_mask(k_line - 2'd1) | line_mask(k_line);
                end
                k_d     = k_q + YW'(1);
                state_d = (k_q == Y_LAST) ? ST_FRAME_END : ST_WAIT_LINE;
            end
            ST_FRAME_END: begin
                rst_line   = 4'hF;
                frame_done = 1'b1;
                k_d        = '0;
                rd_x_d     = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_abort) begin
            rden       = 1'b0;
            re_read    = 4'h0;
            rst_line   = 4'hF;
            frame_done = 1'b0;
            k_d        = '0;
            rd_x_d     = '0;
            state_d    = ST_WAIT_LINE;
        end
    end

    // Write side: a pixel hitting a full or just-cleared line is lost and flagged.
    always_comb begin
        wr_room  = (wr_y_q < Y_LINES);
        wr_block = in_full[wr_line_q] | rst_line[wr_line_q];
        wr_take  = rst_ni & in_pixel_valid & wr_room & ~wr_block;
        wr_drop  = rst_ni & in_pixel_valid & wr_room & wr_block;

        wr_line_d = wr_line_q;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        ovf_d     = ovf_q | wr_drop;

        if (in_frame_start || (state_q == ST_FRAME_END)) begin
            wr_line_d = 2'd0;
            wr_x_d    = '0;
            wr_y_d    = '0;
        end else if (wr_take) begin
            if (wr_x_q == X_LAST) begin
                wr_x_d    = '0;
                wr_line_d = wr_line_q + 2'd1;
                wr_y_d    = wr_y_q + YW'(1);
            end else begin
                wr_x_d = wr_x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            wr_line_q <= 2'd0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            rd_x_q    <= '0;
            k_q       <= '0;
            ovf_q     <= 1'b0;
            rden_p1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_line_q <= wr_line_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            rd_x_q    <= rd_x_d;
            k_q       <= k_d;
            ovf_q     <= ovf_d;
            rden_p1_q <= rden;
        end
    end

    assign ou_data_valid        = wr_take;
    assign ou_line_en_selection = wr_line_q;
    assign ou_buffer_select     = row_active ? win_sel : 2'd0;
    assign ou_load_new_frame    = row_active ? pad : PAD_NONE;
    assign ou_rden              = rden;
    assign ou_re_read           = re_read;
    assign ou_rst_line          = rst_line;
    assign ou_window_valid      = rden_p1_q;
    assign ou_frame_done        = frame_done;
    assign ou_overflow          = ovf_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at WIDTH=4, HEIGHT=4 with a line-buffer
// fill model, a vector table for the write side and hand-built frame sequences.
module tb_line_buffer_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_frame_start, in_pixel_valid, in_ready;
    logic [3:0] in_full;
    logic       ou_data_valid, ou_rden, ou_window_valid, ou_frame_done, ou_overflow;
    logic [1:0] ou_line_en_selection, ou_buffer_select, ou_load_new_frame;
    logic [3:0] ou_re_read, ou_rst_line;

    line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_frame_start      (in_frame_start),
        .in_pixel_valid      (in_pixel_valid),
        .in_full             (in_full),
        .in_ready            (in_ready),
        .ou_data_valid       (ou_data_valid),
        .ou_line_en_selection(ou_line_en_selection),
        .ou_buffer_select    (ou_buffer_select),
        .ou_rden             (ou_rden),
        .ou_re_read          (ou_re_read),
        .ou_rst_line         (ou_rst_line),
        .ou_load_new_frame   (ou_load_new_frame),
        .ou_window_valid     (ou_window_valid),
        .ou_frame_done       (ou_frame_done),
        .ou_overflow         (ou_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [3:0] full;
        logic       rdy;
        logic       exp_dv;
        logic [1:0] exp_sel;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [3:0] re;
        logic [3:0] rst;
        logic [1:0] pad;
        logic [1:0] sel;
        int         reads;
        int         span;
    } rec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Samples of the current cycle, taken on the falling edge.
    logic       s_dv, s_rden, s_wv, s_fd, s_ovf;
    logic [1:0] s_sel, s_bsel, s_pad;
    logic [3:0] s_re, s_rst;

    // Line-buffer fill model driving in_full.
    bit         use_model;
    int         mcnt [4];
    logic [3:0] mfull;

    int   cyc, wv_err, rdy_err, dv_cnt, wv_cnt, last_wv, fd_cnt, fd_cyc;
    int   row_first, row_last, row_reads, pix_left;
    logic prev_rden;
    rec_t recq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        cyc = 0; wv_err = 0; rdy_err = 0; dv_cnt = 0; wv_cnt = 0; last_wv = -1;
        fd_cnt = 0; fd_cyc = -1; row_first = -1; row_last = -1; row_reads = 0;
        prev_rden = 1'b0;
        recq.delete();
    endtask

    task automatic model_clear();
        for (int l = 0; l < 4; l++) mcnt[l] = 0;
        mfull = 4'h0;
    endtask

    task automatic step();
        rec_t r;
        @(negedge clk);
        s_dv = ou_data_valid;   s_sel = ou_line_en_selection; s_bsel = ou_buffer_select;
        s_rden = ou_rden;       s_re = ou_re_read;            s_rst = ou_rst_line;
        s_pad = ou_load_new_frame; s_wv = ou_window_valid;    s_fd = ou_frame_done;
        s_ovf = ou_overflow;
        cyc++;
        if (s_wv !== prev_rden) wv_err++;
        prev_rden = s_rden;
        if (s_rden && !in_ready) rdy_err++;
        if (s_dv) dv_cnt++;
        if (s_rden) begin
            if (row_first < 0) row_first = cyc;
            row_last = cyc;
            row_reads++;
        end
        if (s_wv) begin wv_cnt++; last_wv = cyc; end
        if (s_fd) begin fd_cnt++; fd_cyc = cyc; end
        if (s_re != 4'h0 || s_rst != 4'h0) begin
            r.re = s_re; r.rst = s_rst; r.pad = s_pad; r.sel = s_bsel;
            r.reads = row_reads;
            r.span  = (row_first < 0) ? -1 : row_last - row_first;
            recq.push_back(r);
            row_first = -1; row_reads = 0;
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            if (s_rst[l]) begin
                mcnt[l] = 0; mfull[l] = 1'b0;
            end else if (s_dv && (s_sel == 2'(l))) begin
                mcnt[l]++;
                if (mcnt[l] == W) mfull[l] = 1'b1;
            end
        end
        if (use_model) in_full = mfull;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_frame_start = 1'b0; in_pixel_valid = 1'b0; in_ready = 1'b0; in_full = 4'h0;
        use_model = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mon_clear();
    endtask

    task automatic start_frame();
        in_frame_start = 1'b1; in_pixel_valid = 1'b0;
        step();
        in_frame_start = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, input bit toggle);
        int n = 0;
        while (fd_cnt == 0 && n < max_cyc) begin
            in_pixel_valid = (pix_left > 0);
            if (pix_left > 0) pix_left--;
            in_ready = toggle ? ~in_ready : 1'b1;
            step();
            n++;
        end
    endtask

    vec_t       vecs [9];
    logic [3:0] exp_re  [5];
    logic [3:0] exp_rst [5];
    logic [1:0] exp_pad [4];
    logic [1:0] exp_sel [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        bit   found;
        int   n;

        // pv, in_full, in_ready -> data_valid, line_en_selection, overflow (IDLE, no reads)
        vecs[0] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 4'h2, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[3] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[5] = '{1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[6] = '{1'b1, 4'h1, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[7] = '{1'b1, 4'h2, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[8] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd1, 1'b1};

        exp_re[0]  = 4'b0001; exp_rst[0] = 4'b0000;
        exp_re[1]  = 4'b0011; exp_rst[1] = 4'b0000;
        exp_re[2]  = 4'b0110; exp_rst[2] = 4'b0001;
        exp_re[3]  = 4'b1100; exp_rst[3] = 4'b0010;
        exp_re[4]  = 4'b0000; exp_rst[4] = 4'b1111;
        exp_pad[0] = 2'd1; exp_pad[1] = 2'd2; exp_pad[2] = 2'd0; exp_pad[3] = 2'd0;
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd0; exp_sel[2] = 2'd0; exp_sel[3] = 2'd1;

        // Outputs while reset is held, with live inputs.
        rst_n = 1'b0;
        in_frame_start = 1'b0; in_pixel_valid = 1'b1; in_ready = 1'b1; in_full = 4'h0;
        use_model = 1'b0; model_clear();
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs",
              {ou_data_valid, ou_line_en_selection, ou_buffer_select, ou_rden, ou_re_read,
               ou_rst_line, ou_load_new_frame, ou_window_valid, ou_frame_done, ou_overflow},
              20'h0);

        // Write-side vector table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            in_pixel_valid = vecs[i].pv; in_full = vecs[i].full; in_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_data_valid", i), s_dv, vecs[i].exp_dv);
            check($sformatf("vec%0d_line_sel", i), s_sel, vecs[i].exp_sel);
            check($sformatf("vec%0d_overflow", i), s_ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_rden", i), s_rden, 1'b0);
        end

        // Full frame, continuous ready.
        do_reset();
        use_model = 1'b1; in_full = 4'h0;
        start_frame();
        pix_left = 16;
        run_until_done(300, 1'b0);
        check("A_frame_done_seen", fd_cnt, 1);
        check("A_window_valid_cycles", wv_cnt, 16);
        check("A_pixels_written", dv_cnt, 16);
        check("A_done_after_last_row", fd_cyc, last_wv + 1);
        check("A_wv_follows_rden", wv_err, 0);
        check("A_overflow", s_ovf, 1'b0);
        check("A_records", recq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < recq.size()) begin
                check($sformatf("A_rec%0d_re_read", i), recq[i].re, exp_re[i]);
                check($sformatf("A_rec%0d_rst_line", i), recq[i].rst, exp_rst[i]);
                if (i < 4) begin
                    check($sformatf("A_row%0d_pad", i), recq[i].pad, exp_pad[i]);
                    check($sformatf("A_row%0d_select", i), recq[i].sel, exp_sel[i]);
                    check($sformatf("A_row%0d_reads", i), recq[i].reads, W);
                end else begin
                    check("A_frame_end_done", s_fd | fd_cnt[0], 1'b1);
                end
            end else begin
                check($sformatf("A_rec%0d_present", i), 0, 1);
            end
        end
        step();
        check("A_done_one_cycle", fd_cnt, 1);

        // Full frame with in_ready toggling every cycle.
        do_reset();
        use_model = 1'b1; in_full = 4'h0;
        start_frame();
        pix_left = 16;
        in_ready = 1'b1;
        run_until_done(400, 1'b1);
        check("B_frame_done_seen", fd_cnt, 1);
        check("B_wv_follows_rden", wv_err, 0);
        check("B_rden_needs_ready", rdy_err, 0);
        check("B_window_valid_cycles", wv_cnt, 16);
        for (int i = 0; i < 4; i++) begin
            if (i < recq.size()) begin
                check($sformatf("B_row%0d_reads", i), recq[i].reads, W);
                check($sformatf("B_row%0d_span", i), recq[i].span, 2 * W - 2);
            end else begin
                check($sformatf("B_row%0d_present", i), 0, 1);
            end
        end

        // Writes into full lines: dropped, overflow sticky through an abort.
        do_reset();
        in_ready = 1'b0;
        start_frame();
        in_full = 4'hF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_pixel_valid = 1'b1;
            step();
            if (s_dv) bad++;
        end
        check("C_writes_blocked", bad, 0);
        in_pixel_valid = 1'b0;
        step();
        check("C_overflow_set", s_ovf, 1'b1);
        in_full = 4'h0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            in_pixel_valid = 1'b1;
            step();
            if (!s_dv) bad++;
        end
        check("C_writes_resume", bad, 0);
        in_pixel_valid = 1'b0;
        step();
        check("C_overflow_sticky", s_ovf, 1'b1);
        in_frame_start = 1'b1;
        step();
        in_frame_start = 1'b0;
        check("C_abort_rst_line", s_rst, 4'hF);
        step();
        check("C_abort_pulse_width", s_rst, 4'h0);
        check("C_overflow_kept_on_abort", s_ovf, 1'b1);
        do_reset();
        step();
        check("C_overflow_cleared_by_reset", s_ovf, 1'b0);

        // Abort while reading row 1.
        do_reset();
        use_model = 1'b1; in_full = 4'h0;
        start_frame();
        pix_left = 16; in_ready = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 100) begin
            in_pixel_valid = (pix_left > 0);
            if (pix_left > 0) pix_left--;
            step();
            if (s_rden && s_pad == 2'd2) found = 1'b1;
            n++;
        end
        check("D_reached_row1_read", found, 1'b1);
        in_pixel_valid = 1'b0; pix_left = 0;
        in_frame_start = 1'b1;
        step();
        in_frame_start = 1'b0;
        check("D_abort_rst_line", s_rst, 4'hF);
        check("D_abort_re_read", s_re, 4'h0);
        step();
        check("D_rst_line_one_cycle", s_rst, 4'h0);
        check("D_no_read_after_abort", s_rden, 1'b0);
        check("D_row0_padding", s_pad, 2'd1);
        check("D_write_line_cleared", s_sel, 2'd0);
        check("D_overflow_clear", s_ovf, 1'b0);

        // Asynchronous reset in the middle of a read.
        do_reset();
        use_model = 1'b1; in_full = 4'h0;
        start_frame();
        pix_left = 16; in_ready = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            in_pixel_valid = (pix_left > 0);
            if (pix_left > 0) pix_left--;
            step();
            if (s_rden) found = 1'b1;
            n++;
        end
        check("E_reached_read", found, 1'b1);
        in_pixel_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("E_async_reset_outputs",
              {ou_data_valid, ou_line_en_selection, ou_buffer_select, ou_rden, ou_re_read,
               ou_rst_line, ou_load_new_frame, ou_window_valid, ou_frame_done, ou_overflow},
              20'h0);
        use_model = 1'b0; in_full = 4'hF; in_pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_rden || s_pad != 2'd0) bad++;
        end
        check("E_idle_after_release", bad, 0);
        start_frame();
        found = 1'b0; n = 0;
        while (!found && n < 10) begin
            step();
            if (s_rden) found = 1'b1;
            n++;
        end
        check("E_reads_after_frame_start", found, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, meaning lines per frame (min 3).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_frame_start  input  1  one-cycle pulse before first pixel of a frame.
REQ-007 in_pixel_valid  input  1  camera pixel strobe, never stalls.
REQ-008 in_full  input  4  per-line full flags from the line buffers.
REQ-009 in_ready  input  1  downstream accepts a window this cycle.
REQ-010 ou_data_valid  output  1  gated write strobe to the line buffers.
REQ-011 ou_line_en_selection  output  2  line being written.
REQ-012 ou_buffer_select  output  2  oldest line of the read window.
REQ-013 ou_rden  output  1  read strobe to the line buffers.
REQ-014 ou_re_read  output  4  per-line read-pointer rewind pulse.
REQ-015 ou_rst_line  output  4  per-line clear pulse.
REQ-016 ou_load_new_frame  output  2  top padding: 1 = rows 1,2 zero; 2 = row 2 zero; 0 = none.
REQ-017 ou_window_valid  output  1  3x3 window on the buffer outputs is valid.
REQ-018 ou_frame_done  output  1  one-cycle pulse after the last output row.
REQ-019 ou_overflow  output  1  sticky: a pixel was dropped.

Function
REQ-020 Write side: ou_data_valid = in_pixel_valid AND NOT in_full[wr_line]; a pixel with in_full[wr_line]=1 is dropped and sets ou_overflow.
REQ-021 Write pixel counter counts accepted pixels 0..WIDTH-1; at WIDTH-1, wr_line increments mod 4 and the input line count increments.
REQ-022 Input lines beyond HEIGHT in a frame are dropped without setting ou_overflow.
REQ-023 FSM states: IDLE, WAIT_LINE, READ, ROW_END, FRAME_END.
REQ-024 IDLE -> WAIT_LINE on in_frame_start.
REQ-025 WAIT_LINE -> READ when in_full[k mod 4]=1, where k is the output row index.
REQ-026 In READ, ou_rden = in_ready; the read counter counts asserted ou_rden cycles.
REQ-027 READ -> ROW_END after WIDTH reads.
REQ-028 ou_window_valid SHALL equal ou_rden delayed one cycle (buffer read latency 1).
REQ-029 Row k=0: select 0, load_new_frame 1.
REQ-030 Row k=1: select 0, load_new_frame 2.
REQ-031 Row k>=2: select (k-2) mod 4, load_new_frame 0.
REQ-032 ROW_END (one cycle) at k=0: re_read line 0.
REQ-033 ROW_END at k=1: re_read lines 0 and 1.
REQ-034 ROW_END at k>=2: rst_line the selected line; re_read the other two window lines.
REQ-035 ROW_END: k increments; -> FRAME_END if k=HEIGHT-1, else WAIT_LINE.
REQ-036 FRAME_END (one cycle): ou_rst_line=4'hF, ou_frame_done=1, all counters cleared, -> IDLE.
REQ-037 in_frame_start outside IDLE aborts the frame: one cycle ou_rst_line=4'hF, counters cleared, -> WAIT_LINE; ou_overflow is kept.
REQ-038 Simultaneous write to, and rst_line of, the same line: rst_line wins; the pixel is counted as dropped.

Reset
REQ-039 On rst_n=0: all outputs 0, state IDLE, wr_line 0, all counters 0, ou_overflow 0.
REQ-040 Reset SHALL take effect asynchronously and release synchronously to clk.

Structure
REQ-041 The state encoding and padding codes (PAD_NONE=0, PAD_TOP2=1, PAD_TOP1=2) SHALL live in a shared package.
REQ-042 SHALL be a single module; no sub-module.

Verification (WIDTH=4, HEIGHT=4)
REQ-043 Frame start, 16 contiguous pixels, in_full modelled from writes, in_ready=1 -> 16 window-valid cycles; load_new_frame sequence 1,2,0,0; select 0,0,0,1; ou_frame_done one cycle after the last row.
REQ-044 in_ready toggling every cycle -> ou_rden follows in_ready; each row takes 8 cycles; ou_window_valid = ou_rden delayed one cycle.
REQ-045 Hold in_full=4'hF while 5 pixels arrive -> ou_data_valid=0 throughout, ou_overflow=1 and stays 1 until reset.
REQ-046 Row 2 ROW_END -> ou_rst_line=4'b0001, ou_re_read=4'b0110, for exactly one cycle.
REQ-047 in_frame_start during READ of row 1 -> ou_rst_line=4'hF for one cycle, state WAIT_LINE, k=0.
REQ-048 rst_n low mid-READ -> all outputs 0 immediately; after release, IDLE with no ou_rden until in_frame_start.
